// File: rtl/mpu_pkg.sv
// Shared constants, loader state encoding and element offset helper for the
// MPU matrix loader.
package mpu_pkg;

  localparam int MPU_DIM      = 5;
  localparam int MPU_ELEM_W   = 8;
  localparam int MPU_MATRIX_W = MPU_DIM * MPU_DIM * MPU_ELEM_W;
  localparam int MPU_IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Bit offset of element (row, col) inside the flat matrix bus.
  function automatic logic [7:0] at(input logic [MPU_IDX_W-1:0] row,
                                    input logic [MPU_IDX_W-1:0] col);
    return 8'(row) * 8'(MPU_DIM * MPU_ELEM_W) + 8'(col) * 8'(MPU_ELEM_W);
  endfunction

endpackage

// File: rtl/mpu_elem_counter.sv
// Row/column position counter for the matrix loader; wraps the column at the
// runtime dimension and flags the final element of a size x size load.
module mpu_elem_counter
  import mpu_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [7:0]           size,
  output logic [MPU_IDX_W-1:0] row,
  output logic [MPU_IDX_W-1:0] col,
  output logic                 last
);

  logic [MPU_IDX_W-1:0] row_q, row_d;
  logic [MPU_IDX_W-1:0] col_q, col_d;
  logic [7:0]           lim;

  assign lim  = size - 8'd1;
  assign last = (8'(row_q) == lim) && (8'(col_q) == lim);
  assign row  = row_q;
  assign col  = col_q;

  // Next position: clear wins, otherwise advance column and wrap into next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (8'(col_q) == lim) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Matrix loader: takes a size code and a row-major element stream over
// valid/ready, packs it into the flat 5x5 bus and holds it for the
// determinant consumer until accepted.
// Optional build macro MPU_LOADER_TRANSPOSE_EN: treat the stream as
// column-major (element k lands at (col,row)); counters/handshake unchanged.
module mpu_matrix_loader
  import mpu_pkg::*;
(
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              start_size,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MPU_ELEM_W-1:0]   in_data,
  output logic [0:MPU_MATRIX_W-1] matrix,
  output logic [7:0]              size,
  output logic                    matrix_valid,
  input  logic                    matrix_ready,
  output logic                    busy,
  output logic                    size_err
);

  loader_state_e           state_q, state_d;
  logic [0:MPU_MATRIX_W-1] matrix_q, matrix_d;
  logic [7:0]              size_q, size_d;
  logic                    in_ready_q, in_ready_d;
  logic                    matrix_valid_q, matrix_valid_d;
  logic                    size_err_q, size_err_d;

  logic                    accept;
  logic                    cnt_clr;
  logic                    last;
  logic [MPU_IDX_W-1:0]    row;
  logic [MPU_IDX_W-1:0]    col;
  logic [7:0]              wr_off;

  // in_ready_q is only ever high in LOAD, so it alone qualifies the write.
  assign accept = in_valid && in_ready_q;

`ifdef MPU_LOADER_TRANSPOSE_EN
  assign wr_off = at(col, row);
`else
  assign wr_off = at(row, col);
`endif

  mpu_elem_counter u_cnt (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (accept),
    .size  (size_q),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  // Loader FSM: next state, matrix writes and registered handshake outputs.
  always_comb begin
    state_d        = state_q;
    matrix_d       = matrix_q;
    size_d         = size_q;
    in_ready_d     = in_ready_q;
    matrix_valid_d = matrix_valid_q;
    size_err_d     = size_err_q;
    cnt_clr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((start_size != 8'd0) && (start_size <= 8'(MPU_DIM))) begin
            size_d     = start_size;
            matrix_d   = '0;
            cnt_clr    = 1'b1;
            size_err_d = 1'b0;
            state_d    = LOAD;
          end else begin
            size_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // Ready rises one cycle after entry since it is derived from state_q.
        in_ready_d = 1'b1;
        if (accept) begin
          matrix_d[wr_off +: MPU_ELEM_W] = in_data;
          if (last) begin
            in_ready_d     = 1'b0;
            matrix_valid_d = 1'b1;
            state_d        = DONE;
          end
        end
      end
      DONE: begin
        if (matrix_ready) begin
          matrix_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      matrix_q       <= '0;
      size_q         <= '0;
      in_ready_q     <= 1'b0;
      matrix_valid_q <= 1'b0;
      size_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      matrix_q       <= matrix_d;
      size_q         <= size_d;
      in_ready_q     <= in_ready_d;
      matrix_valid_q <= matrix_valid_d;
      size_err_q     <= size_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign matrix       = matrix_q;
  assign size         = size_q;
  assign matrix_valid = matrix_valid_q;
  assign size_err     = size_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: random streams and handshake
// timing against a placement model built from the element index k.
// Honours MPU_LOADER_TRANSPOSE_EN in the model when the build defines it.
module tb_mpu_matrix_loader;
  import mpu_pkg::*;

  logic                    clock;
  logic                    rst_n;
  logic                    start;
  logic [7:0]              start_size;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  logic [0:MPU_MATRIX_W-1] matrix;
  logic [7:0]              size;
  logic                    matrix_valid;
  logic                    matrix_ready;
  logic                    busy;
  logic                    size_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]              stim [25];
  logic [0:MPU_MATRIX_W-1] last_exp;

  mpu_matrix_loader dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .start        (start),
    .start_size   (start_size),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .matrix       (matrix),
    .size         (size),
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready),
    .busy         (busy),
    .size_err     (size_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [MPU_MATRIX_W-1:0] obs,
                       input logic [MPU_MATRIX_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected matrix: element k goes to row k/n, col k%n (swapped if transposed).
  function automatic logic [0:MPU_MATRIX_W-1] model(input int n);
    logic [0:MPU_MATRIX_W-1] m;
    int r, c;
    m = '0;
    for (int k = 0; k < n * n; k++) begin
`ifdef MPU_LOADER_TRANSPOSE_EN
      c = k / n;
      r = k % n;
`else
      r = k / n;
      c = k % n;
`endif
      m[r * 40 + c * 8 +: 8] = stim[k];
    end
    return m;
  endfunction

  function automatic logic [7:0] elem(input logic [0:MPU_MATRIX_W-1] m, input int r, input int c);
    return m[r * 40 + c * 8 +: 8];
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_matrix"}, matrix, '0);
    check({tag, "_size"}, size, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mvalid"}, matrix_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_size_err"}, size_err, 0);
  endtask

  // One load of an n x n matrix from stim[]. gaps: random in_valid holes;
  // ready_dly: cycles matrix_valid is held before accept; abort_at: assert
  // reset once that many elements are in; poke: pulse start in LOAD and DONE.
  task automatic run_load(input int n, input bit gaps, input int ready_dly,
                          input int abort_at, input bit poke, input string tag);
    logic [0:MPU_MATRIX_W-1] exp_m;
    int  idx;
    int  cyc;
    bit  v;
    exp_m = model(n);
    @(negedge clock);
    start      = 1'b1;
    start_size = 8'(n);
    @(negedge clock);
    start = 1'b0;
    cyc   = 1;
    idx   = 0;
    while (!matrix_valid && cyc < 400) begin
      if (poke && cyc == 3) begin
        start      = 1'b1;
        start_size = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (idx < n * n) begin
        v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_valid = v;
        in_data  = stim[idx];
        if (v && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
      if (abort_at != 0 && idx == abort_at) begin
        in_valid = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_vals({tag, "_rst"});
        @(negedge clock);
        rst_n = 1'b1;
        return;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, "_valid"}, matrix_valid, 1);
    if (!gaps) check({tag, "_latency"}, cyc, n * n + 2);
    check({tag, "_size"}, size, n);
    check({tag, "_matrix"}, matrix, exp_m);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_low"}, in_ready, 0);
    if (poke) begin
      start      = 1'b1;
      start_size = 8'd1;
    end
    for (int i = 0; i < ready_dly; i++) begin
      @(negedge clock);
      start = 1'b0;
      check({tag, "_hold_matrix"}, matrix, exp_m);
      check({tag, "_hold_valid"}, matrix_valid, 1);
    end
    start        = 1'b0;
    matrix_ready = 1'b1;
    @(negedge clock);
    matrix_ready = 1'b0;
    check({tag, "_drop"}, matrix_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_retain"}, matrix, exp_m);
    check({tag, "_retain_size"}, size, n);
    last_exp = exp_m;
  endtask

  task automatic bad_start(input logic [7:0] sz, input string tag);
    @(negedge clock);
    start      = 1'b1;
    start_size = sz;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_size_err"}, size_err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_matrix"}, matrix, last_exp);
    check({tag, "_size"}, size, 5);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    start_size   = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    matrix_ready = 1'b0;
    last_exp     = '0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clock);
    check_reset_vals("post_reset");

    // 2x2, 1..4, no gaps
    for (int k = 0; k < 4; k++) stim[k] = 8'(k + 1);
    run_load(2, 1'b0, 2, 0, 1'b0, "t1");
`ifdef MPU_LOADER_TRANSPOSE_EN
    check("t1_e01", elem(matrix, 0, 1), 3);
    check("t1_e10", elem(matrix, 1, 0), 2);
`else
    check("t1_e01", elem(matrix, 0, 1), 2);
    check("t1_e10", elem(matrix, 1, 0), 3);
`endif
    check("t1_e22", elem(matrix, 2, 2), 0);

    // 5x5, 0..24, random gaps, long accept delay
    for (int k = 0; k < 25; k++) stim[k] = 8'(k);
    run_load(5, 1'b1, 10, 0, 1'b0, "t2");
`ifdef MPU_LOADER_TRANSPOSE_EN
    check("t2_e43", elem(matrix, 4, 3), 19);
`else
    check("t2_e43", elem(matrix, 4, 3), 23);
`endif

    // illegal sizes, then a legal 1x1 load of -7
    bad_start(8'd0, "t3_zero");
    bad_start(8'd6, "t3_six");
    stim[0] = 8'hF9;
    run_load(1, 1'b0, 1, 0, 1'b0, "t3_one");
    check("t3_err_clr", size_err, 0);
    check("t3_e00", elem(matrix, 0, 0), 8'hF9);

    // reset after 7 of 9 elements, then a fresh 3x3 load
    for (int k = 0; k < 9; k++) stim[k] = 8'($urandom);
    run_load(3, 1'b0, 0, 7, 1'b0, "t4_abort");
    for (int k = 0; k < 9; k++) stim[k] = 8'($urandom);
    run_load(3, 1'b0, 1, 0, 1'b0, "t4_fresh");

    // start pulses during LOAD and DONE must be ignored
    for (int k = 0; k < 16; k++) stim[k] = 8'($urandom);
    run_load(4, 1'b1, 3, 0, 1'b1, "t5");

    // 3x3, 1..9 placement
    for (int k = 0; k < 9; k++) stim[k] = 8'(k + 1);
    run_load(3, 1'b0, 1, 0, 1'b0, "t6");
`ifdef MPU_LOADER_TRANSPOSE_EN
    check("t6_e01", elem(matrix, 0, 1), 4);
    check("t6_e10", elem(matrix, 1, 0), 2);
    check("t6_e20", elem(matrix, 2, 0), 3);
`else
    check("t6_e01", elem(matrix, 0, 1), 2);
    check("t6_e10", elem(matrix, 1, 0), 4);
    check("t6_e20", elem(matrix, 2, 0), 7);
`endif

    // random sizes, data, gaps and accept delays
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < 25; k++) stim[k] = 8'($urandom);
      run_load(n, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0, 1'b0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
